// File: rtl/rename_pkg.sv
// Shared sizing and types for the rename register file / RAT slice.
// The module parameters default to these values; the typedefs describe the default configuration.
package rename_pkg;
    localparam int NREG  = 32;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int NSRC  = 2;
    localparam int RW    = $clog2(NREG);

    typedef logic [RW-1:0]    reg_idx_t;
    typedef logic [TAG_W-1:0] rob_tag_t;
    typedef logic [XLEN-1:0]  xlen_t;
endpackage

// File: rtl/rename_regfile_if.sv
// Commit, rename-request and response signals between dispatch/ROB (master) and the RAT (slave).
interface rename_regfile_if #(
    parameter int NREG  = rename_pkg::NREG,
    parameter int XLEN  = rename_pkg::XLEN,
    parameter int TAG_W = rename_pkg::TAG_W,
    parameter int NSRC  = rename_pkg::NSRC
);
    localparam int RW = $clog2(NREG);

    logic                  cm_valid;
    logic [RW-1:0]         cm_rd;
    logic [TAG_W-1:0]      cm_tag;
    logic [XLEN-1:0]       cm_value;

    logic                  rn_valid;
    logic [TAG_W-1:0]      rn_id;
    logic [NSRC-1:0]       rn_src_en;
    logic [NSRC*RW-1:0]    rn_src;
    logic                  rn_has_rd;
    logic [RW-1:0]         rn_rd;

    logic                  rsp_valid;
    logic [TAG_W-1:0]      rsp_id;
    logic [NSRC-1:0]       rsp_busy;
    logic [NSRC*TAG_W-1:0] rsp_tag;
    logic [NSRC*XLEN-1:0]  rsp_data;

    modport master (
        output cm_valid, cm_rd, cm_tag, cm_value,
        output rn_valid, rn_id, rn_src_en, rn_src, rn_has_rd, rn_rd,
        input  rsp_valid, rsp_id, rsp_busy, rsp_tag, rsp_data
    );

    modport slave (
        input  cm_valid, cm_rd, cm_tag, cm_value,
        input  rn_valid, rn_id, rn_src_en, rn_src, rn_has_rd, rn_rd,
        output rsp_valid, rsp_id, rsp_busy, rsp_tag, rsp_data
    );
endinterface

// File: rtl/rename_src_port.sv
// Combinational lookup for one source operand: value, producer tag, or same-cycle commit bypass.
// The bypass is built only when RENAME_REGFILE_COMMIT_BYPASS_EN is defined.
module rename_src_port #(
    parameter int RW    = rename_pkg::RW,
    parameter int TAG_W = rename_pkg::TAG_W,
    parameter int XLEN  = rename_pkg::XLEN
) (
    input  logic             i_en,
    input  logic [RW-1:0]    i_src,
    input  logic             i_busy,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [XLEN-1:0]  i_value,
`ifdef RENAME_REGFILE_COMMIT_BYPASS_EN
    input  logic             i_cm_valid,
    input  logic [RW-1:0]    i_cm_rd,
    input  logic [TAG_W-1:0] i_cm_tag,
    input  logic [XLEN-1:0]  i_cm_value,
`endif
    output logic             o_busy,
    output logic [TAG_W-1:0] o_tag,
    output logic [XLEN-1:0]  o_data
);

`ifdef RENAME_REGFILE_COMMIT_BYPASS_EN
    // Only the producer currently owning the register may resolve it early.
    logic w_bypass;
    assign w_bypass = i_cm_valid && (i_cm_rd == i_src) && (i_cm_tag == i_tag);
`endif

    always_comb begin
        o_busy = 1'b0;
        o_tag  = '0;
        o_data = '0;
        if (i_en && (i_src != '0)) begin
            if (!i_busy) begin
                o_data = i_value;
            end
`ifdef RENAME_REGFILE_COMMIT_BYPASS_EN
            else if (w_bypass) begin
                o_data = i_cm_value;
            end
`endif
            else begin
                o_busy = 1'b1;
                o_tag  = i_tag;
            end
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file plus RAT: NSRC-port rename lookup with a 1-cycle registered response.
// Optional same-cycle commit bypass: RENAME_REGFILE_COMMIT_BYPASS_EN.
module rename_regfile #(
    parameter int NREG  = rename_pkg::NREG,
    parameter int XLEN  = rename_pkg::XLEN,
    parameter int TAG_W = rename_pkg::TAG_W,
    parameter int NSRC  = rename_pkg::NSRC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    rename_regfile_if.slave   bus
);
    localparam int RW = $clog2(NREG);

    logic [NREG-1:0]       w_busy;
    logic [TAG_W-1:0]      w_tag   [NREG];
    logic [XLEN-1:0]       w_value [NREG];

    logic                  w_cm_wr;
    logic                  w_rn_wr;

    logic [NSRC-1:0]       w_port_busy;
    logic [NSRC*TAG_W-1:0] w_port_tag;
    logic [NSRC*XLEN-1:0]  w_port_data;

    logic                  r_rsp_valid;
    logic [TAG_W-1:0]      r_rsp_id;
    logic [NSRC-1:0]       r_rsp_busy;
    logic [NSRC*TAG_W-1:0] r_rsp_tag;
    logic [NSRC*XLEN-1:0]  r_rsp_data;

    assign w_cm_wr = bus.cm_valid && (bus.cm_rd != '0);
    assign w_rn_wr = bus.rn_valid && bus.rn_has_rd && (bus.rn_rd != '0) && !flush;

    genvar gi;

    // x0 is never addressed by either write enable, so its entry stays at its reset value.
    for (gi = 0; gi < NREG; gi++) begin : g_reg
        logic             r_busy;
        logic [TAG_W-1:0] r_tag;
        logic [XLEN-1:0]  r_value;
        logic             w_cm_hit;
        logic             w_rn_hit;

        assign w_cm_hit = w_cm_wr && (bus.cm_rd == RW'(gi));
        assign w_rn_hit = w_rn_wr && (bus.rn_rd == RW'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_busy  <= 1'b0;
                r_tag   <= '0;
                r_value <= '0;
            end else if (rdy) begin
                if (w_cm_hit) begin
                    r_value <= bus.cm_value;
                end
                // Rename beats a same-cycle commit; a stale commit tag leaves the newer producer busy.
                if (flush) begin
                    r_busy <= 1'b0;
                end else if (w_rn_hit) begin
                    r_busy <= 1'b1;
                    r_tag  <= bus.rn_id;
                end else if (w_cm_hit && (r_tag == bus.cm_tag)) begin
                    r_busy <= 1'b0;
                end
            end
        end

        assign w_busy[gi]  = r_busy;
        assign w_tag[gi]   = r_tag;
        assign w_value[gi] = r_value;
    end

    for (gi = 0; gi < NSRC; gi++) begin : g_port
        logic [RW-1:0] w_src;
        assign w_src = bus.rn_src[gi*RW +: RW];

        rename_src_port #(
            .RW    (RW),
            .TAG_W (TAG_W),
            .XLEN  (XLEN)
        ) u_src_port (
            .i_en       (bus.rn_src_en[gi]),
            .i_src      (w_src),
            .i_busy     (w_busy[w_src]),
            .i_tag      (w_tag[w_src]),
            .i_value    (w_value[w_src]),
`ifdef RENAME_REGFILE_COMMIT_BYPASS_EN
            .i_cm_valid (bus.cm_valid),
            .i_cm_rd    (bus.cm_rd),
            .i_cm_tag   (bus.cm_tag),
            .i_cm_value (bus.cm_value),
`endif
            .o_busy     (w_port_busy[gi]),
            .o_tag      (w_port_tag[gi*TAG_W +: TAG_W]),
            .o_data     (w_port_data[gi*XLEN +: XLEN])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_busy  <= '0;
            r_rsp_tag   <= '0;
            r_rsp_data  <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_rsp_valid <= 1'b0;
            end else begin
                r_rsp_valid <= bus.rn_valid;
                if (bus.rn_valid) begin
                    r_rsp_id   <= bus.rn_id;
                    r_rsp_busy <= w_port_busy;
                    r_rsp_tag  <= w_port_tag;
                    r_rsp_data <= w_port_data;
                end
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_busy  = r_rsp_busy;
    assign bus.rsp_tag   = r_rsp_tag;
    assign bus.rsp_data  = r_rsp_data;

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file plus register alias table (RAT) for the Tomasulo core.
- Sits between decode/dispatch and the reservation stations, and receives commits from the ROB.
- Per rename request it reads NSRC source operands, returning either a value or a ROB tag. It also records a new producer tag for rd.
- Over the single-port predecessor it adds: generic source-port count, a consistent same-cycle commit bypass on every port, and an explicit request/response handshake.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- XLEN, 32, data width.
- TAG_W, 4, ROB tag width.
- NSRC, 2, number of source-operand read ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state and outputs
- flush  in  1  mispredict flush: clears all busy bits
- cm_valid  in  1  ROB commit strobe
- cm_rd  in  $clog2(NREG)  commit destination register
- cm_tag  in  TAG_W  ROB tag of committing instruction
- cm_value  in  XLEN  committed value
- rn_valid  in  1  rename request
- rn_id  in  TAG_W  ROB tag of requesting instruction
- rn_src_en  in  NSRC  per-port source-used flags
- rn_src  in  NSRC*$clog2(NREG)  flattened source register indices; port k at bits [k*RW +: RW]
- rn_has_rd  in  1  instruction writes rd (0 for branch/store)
- rn_rd  in  $clog2(NREG)  destination register
- rsp_valid  out  1  response valid, one cycle after the request
- rsp_id  out  TAG_W  echoed rn_id
- rsp_busy  out  NSRC  per-port: operand not yet available
- rsp_tag  out  NSRC*TAG_W  per-port producer tag, valid when busy
- rsp_data  out  NSRC*XLEN  per-port value, valid when not busy

Behaviour:
- Reset: all value[i]=0, busy[i]=0, tag[i]=0. rsp_valid, rsp_id, rsp_busy, rsp_tag and rsp_data all 0.
- rdy=0: no state changes; outputs hold their values.
- Latency: exactly 1 cycle. The request is sampled at edge N and rsp_* is valid after edge N, for one cycle only. A new request is accepted every cycle, and no ready/backpressure signal exists.
- Commit (cm_valid, cm_rd!=0): value[cm_rd] <= cm_value. busy[cm_rd] clears only if tag[cm_rd]==cm_tag, otherwise a younger producer owns the register. A commit to cm_rd=0 is ignored.
- Source port k with rn_src_en[k]=0: rsp_busy[k]=0 and data/tag = 0.
- Source port k with rn_src_en[k]=1:
  - busy[src]=0: busy=0, data=value[src].
  - busy[src]=1: busy=1, tag=tag[src].
  - src=0: always busy=0, data=0.
- Commit bypass: if cm_valid, cm_rd==src!=0, busy[src]=1 and tag[src]==cm_tag, then rsp_busy[k]=0 and rsp_data[k]=cm_value. This applies on every port identically.
- Sources are looked up against the RAT before this request's own rd update, so `add x1,x1,x1` sees the old producer.
- rd update (rn_valid, rn_has_rd, rn_rd!=0): busy[rn_rd]<=1, tag[rn_rd]<=rn_id. rn_rd=0 is never marked busy.
- Same-register rename and commit in one cycle: the rename wins. busy stays 1 and tag becomes rn_id; the commit value is still written.
- flush=1: all busy<=0 and rsp_valid<=0. A rename in the same cycle is dropped (no rd update, no response). A commit in the same cycle still writes its value.
- Reset has priority over everything, including mid-request; no response is produced.

Optional Feature:
- Macro RENAME_REGFILE_COMMIT_BYPASS_EN.
- Defined: the commit bypass above is active.
- Undefined: no bypass. Sources read busy/tag/value as registered before the edge, so a commit landing in the same cycle is reported busy with its tag. This relies on the reservation stations catching the broadcast on the CDB instead.

Decomposition:
- Shared package rename_pkg: localparam RW=$clog2(NREG), typedef reg_idx_t, typedef rob_tag_t, typedef xlen_t.
- One natural sub-module: rename_src_port, the combinational per-port lookup plus bypass, instantiated NSRC times with generate.
- The top level holds the arrays, the commit/rename write logic and the response registers.

Test Plan:
- Reset, then rename id=3, srcs x5,x6, rd=x5 → rsp busy=00, data=0,0. Next cycle a request with src x5 → busy[0]=1, tag=3.
- Commit x5 tag=3 value=0xDEAD in the same cycle as a request for src x5 → with the macro: busy=0, data=0xDEAD. Without the macro: busy=1, tag=3. In both cases a later read gives 0xDEAD, not busy.
- Rename rd=x7 id=4, then id=9. Commit x7 tag=4 value=0x11 → x7 stays busy with tag=9; a read returns busy, tag=9.
- Commit x7 tag=9 and rename rd=x7 id=2 in the same cycle → busy=1, tag=2, and value[x7] holds the committed data.
- Mark x1..x3 busy, then flush together with a rename request → rsp_valid=0 next cycle; all later reads are not busy and return the last committed values.
- Rename rd=x0 and commit x0 value=0x55 → a read of x0 gives busy=0, data=0. A rename with rdy=0 → no response and no state change.
